tmr_resp_splitter: RTL and testbench

Return-path companion to the TMR request voter. It takes the single OBI response (gnt, rvalid, rdata) from the instruction bus and from the data bus and redistributes it to the three redundant harts. It tracks outstanding transactions per bus and per hart, so a hart that did not take part in the voted request never receives a stray rvalid. It flags protocol errors (spurious response, missing hart participation, outstanding overflow, response timeout) to the TMR control logic.

---
 rtl/tmr_resp_splitter_pkg.sv | 18 +
 rtl/tmr_resp_splitter.sv | 147 ++++++++++++++
 tb/tb_tmr_resp_splitter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_resp_splitter_pkg.sv
// Default OBI request/response types for the TMR response splitter.
package tmr_resp_splitter_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/tmr_resp_splitter.sv
// Distributes instruction/data OBI responses to three redundant harts, tracking
// outstanding transactions per bus and per hart and flagging protocol errors.
module tmr_resp_splitter #(
  parameter type         obi_req_t       = tmr_resp_splitter_pkg::obi_req_t,
  parameter type         obi_resp_t      = tmr_resp_splitter_pkg::obi_resp_t,
  parameter int unsigned NHARTS          = 3,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT         = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  obi_req_t  [NHARTS-1:0]       core_instr_req_i,
  input  obi_resp_t                    bus_instr_resp_i,
  output obi_resp_t [NHARTS-1:0]       core_instr_resp_o,
  input  obi_req_t  [NHARTS-1:0]       core_data_req_i,
  input  obi_resp_t                    bus_data_resp_i,
  output obi_resp_t [NHARTS-1:0]       core_data_resp_o,
  input  logic                         enable_i,
  output logic                         error_o,
  output logic      [NHARTS-1:0]       error_id_o,
  output logic                         timeout_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  // Channel 0 is instruction, channel 1 is data.
  logic      [NHARTS-1:0] req_v  [2];
  obi_resp_t              bus_v  [2];
  obi_resp_t [NHARTS-1:0] resp_v [2];

  logic [CW-1:0] bcnt_q [2];
  logic [CW-1:0] bcnt_d [2];
  logic [CW-1:0] hcnt_q [2][NHARTS];
  logic [CW-1:0] hcnt_d [2][NHARTS];
  logic [TW-1:0] tmr_q  [2];
  logic [TW-1:0] tmr_d  [2];

  logic              error_q, error_d;
  logic [NHARTS-1:0] error_id_q, error_id_d;
  logic              timeout_q, timeout_d;

  logic unused_req_fields;
  assign unused_req_fields = ^{core_instr_req_i, core_data_req_i};

  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] v,
                                             input logic inc, input logic dec);
    if (inc && !dec && v != CNT_MAX) return v + CW'(1);
    if (dec && !inc && v != '0)      return v - CW'(1);
    return v;
  endfunction

  always_comb begin
    for (int unsigned h = 0; h < NHARTS; h++) begin
      req_v[0][h] = core_instr_req_i[h].req;
      req_v[1][h] = core_data_req_i[h].req;
    end
    bus_v[0] = bus_instr_resp_i;
    bus_v[1] = bus_data_resp_i;
  end

  assign core_instr_resp_o = resp_v[0];
  assign core_data_resp_o  = resp_v[1];

  always_comb begin
    logic vreq, accept, rv, bzero, hit;
    vreq       = 1'b0;
    accept     = 1'b0;
    rv         = 1'b0;
    bzero      = 1'b0;
    hit        = 1'b0;
    error_d    = 1'b0;
    error_id_d = '0;
    timeout_d  = 1'b0;
    bcnt_d     = bcnt_q;
    hcnt_d     = hcnt_q;
    tmr_d      = tmr_q;
    for (int unsigned c = 0; c < 2; c++) begin
      vreq   = ($countones(req_v[c]) > int'(NHARTS / 2));
      accept = vreq & bus_v[c].gnt;
      rv     = bus_v[c].rvalid;
      bzero  = (bcnt_q[c] == '0);
      for (int unsigned h = 0; h < NHARTS; h++) begin
        resp_v[c][h] = bus_v[c];
        if (enable_i) begin
          resp_v[c][h].gnt    = accept & req_v[c][h];
          resp_v[c][h].rvalid = rv & (hcnt_q[c][h] != '0);
        end
      end
      if (!enable_i) begin
        bcnt_d[c] = '0;
        tmr_d[c]  = '0;
        for (int unsigned h = 0; h < NHARTS; h++) hcnt_d[c][h] = '0;
      end else begin
        // A same-cycle rvalid suppresses the timeout.
        hit = !bzero && !rv && (tmr_q[c] == TMR_LAST);
        if ((rv && bzero) || (accept && bcnt_q[c] == CNT_MAX && !rv) || hit)
          error_d = 1'b1;
        for (int unsigned h = 0; h < NHARTS; h++) begin
          if (rv && !bzero && hcnt_q[c][h] == '0) begin
            error_id_d[h] = 1'b1;
            error_d       = 1'b1;
          end
        end
        if (hit) begin
          timeout_d = 1'b1;
          bcnt_d[c] = '0;
          tmr_d[c]  = '0;
          for (int unsigned h = 0; h < NHARTS; h++) hcnt_d[c][h] = '0;
        end else begin
          bcnt_d[c] = sat_step(bcnt_q[c], accept, rv);
          for (int unsigned h = 0; h < NHARTS; h++)
            hcnt_d[c][h] = sat_step(hcnt_q[c][h], accept & req_v[c][h],
                                    rv & (hcnt_q[c][h] != '0));
          tmr_d[c] = (bzero || rv) ? '0 : tmr_q[c] + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < 2; c++) begin
        bcnt_q[c] <= '0;
        tmr_q[c]  <= '0;
        for (int unsigned h = 0; h < NHARTS; h++) hcnt_q[c][h] <= '0;
      end
      error_q    <= 1'b0;
      error_id_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      hcnt_q     <= hcnt_d;
      tmr_q      <= tmr_d;
      error_q    <= error_d;
      error_id_q <= error_id_d;
      timeout_q  <= timeout_d;
    end
  end

  assign error_o    = error_q;
  assign error_id_o = error_id_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_tmr_resp_splitter.sv
// Scoreboard bench for tmr_resp_splitter: a transaction-count reference model
// predicts each cycle's outputs; a monitor compares them on the falling edge.
module tb_tmr_resp_splitter;
  import tmr_resp_splitter_pkg::*;

  localparam int MAXO = 2;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  obi_req_t  [2:0] ireq = '0;
  obi_req_t  [2:0] dreq = '0;
  obi_resp_t       ibus = '0;
  obi_resp_t       dbus = '0;
  obi_resp_t [2:0] iresp;
  obi_resp_t [2:0] dresp;
  logic            err;
  logic [2:0]      eid;
  logic            tmo;

  always #5 clk = ~clk;

  tmr_resp_splitter #(
    .NHARTS(3), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_instr_req_i(ireq), .bus_instr_resp_i(ibus), .core_instr_resp_o(iresp),
    .core_data_req_i(dreq), .bus_data_resp_i(dbus), .core_data_resp_o(dresp),
    .enable_i(en), .error_o(err), .error_id_o(eid), .timeout_o(tmo)
  );

  typedef struct packed {
    logic [2:0]  gi, ri, gd, rd;
    logic [31:0] xi, xd;
    logic        err;
    logic [2:0]  id;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: outstanding counts as plain integers.
  int m_bc[2];
  int m_hc[2][3];
  int m_tm[2];
  bit p_err, p_to;
  bit [2:0] p_id;

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > MAXO) ? MAXO : v);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_bc[c] = 0;
      m_tm[c] = 0;
      for (int h = 0; h < 3; h++) m_hc[c][h] = 0;
    end
  endtask

  task automatic step(input bit rn, input bit eb,
                      input logic [2:0] ir, input bit ig, input bit iv, input logic [31:0] ix,
                      input logic [2:0] dr, input bit dg, input bit dv, input logic [31:0] dx);
    exp_t e;
    logic [2:0] r[2];
    bit g[2], v[2];
    logic [2:0] eg[2], er[2];
    bit n_err, n_to;
    bit [2:0] n_id;
    int votes, bc_old;
    bit acc, spur, ovf, tout;
    @(posedge clk);
    #1;
    rst_n = rn;
    en    = eb;
    for (int h = 0; h < 3; h++) begin
      ireq[h].req  = ir[h];
      ireq[h].addr = $urandom;
      dreq[h].req  = dr[h];
      dreq[h].addr = $urandom;
    end
    ibus.gnt = ig; ibus.rvalid = iv; ibus.rdata = ix;
    dbus.gnt = dg; dbus.rvalid = dv; dbus.rdata = dx;
    r[0] = ir; g[0] = ig; v[0] = iv;
    r[1] = dr; g[1] = dg; v[1] = dv;
    if (!rn) begin
      model_clear();
      p_err = 0; p_to = 0; p_id = '0;
    end
    e = '0;
    e.err = p_err; e.id = p_id; e.to = p_to;
    e.xi = ix; e.xd = dx;
    n_err = 0; n_to = 0; n_id = '0;
    for (int c = 0; c < 2; c++) begin
      votes = int'(r[c][0]) + int'(r[c][1]) + int'(r[c][2]);
      acc = (votes >= 2) && g[c];
      if (!eb) begin
        eg[c] = {3{g[c]}};
        er[c] = {3{v[c]}};
        m_bc[c] = 0; m_tm[c] = 0;
        for (int h = 0; h < 3; h++) m_hc[c][h] = 0;
      end else begin
        for (int h = 0; h < 3; h++) begin
          eg[c][h] = acc && r[c][h];
          er[c][h] = v[c] && (m_hc[c][h] > 0);
        end
        if (rn) begin
          spur = v[c] && (m_bc[c] == 0);
          ovf  = acc && (m_bc[c] == MAXO) && !v[c];
          tout = (m_bc[c] > 0) && !v[c] && (m_tm[c] == TMO - 1);
          if (spur || ovf) n_err = 1;
          if (v[c] && m_bc[c] > 0)
            for (int h = 0; h < 3; h++)
              if (m_hc[c][h] == 0) begin n_id[h] = 1; n_err = 1; end
          bc_old  = m_bc[c];
          m_bc[c] = clamp(m_bc[c] + int'(acc) - int'(v[c]));
          for (int h = 0; h < 3; h++)
            m_hc[c][h] = clamp(m_hc[c][h] + int'(acc && r[c][h])
                               - int'(v[c] && m_hc[c][h] > 0));
          m_tm[c] = (bc_old > 0 && !v[c]) ? m_tm[c] + 1 : 0;
          if (tout) begin
            n_to = 1; n_err = 1;
            m_bc[c] = 0; m_tm[c] = 0;
            for (int h = 0; h < 3; h++) m_hc[c][h] = 0;
          end
        end
      end
    end
    e.gi = eg[0]; e.ri = er[0]; e.gd = eg[1]; e.rd = er[1];
    sb.push_back(e);
    p_err = n_err; p_to = n_to; p_id = n_id;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    logic [2:0] a_gi, a_ri, a_gd, a_rd;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int h = 0; h < 3; h++) begin
          a_gi[h] = iresp[h].gnt; a_ri[h] = iresp[h].rvalid;
          a_gd[h] = dresp[h].gnt; a_rd[h] = dresp[h].rvalid;
          chk("instr_rdata", iresp[h].rdata, e.xi);
          chk("data_rdata", dresp[h].rdata, e.xd);
        end
        chk("instr_gnt", a_gi, e.gi);
        chk("instr_rvalid", a_ri, e.ri);
        chk("data_gnt", a_gd, e.gd);
        chk("data_rvalid", a_rd, e.rd);
        chk("error_o", err, e.err);
        chk("error_id_o", eid, e.id);
        chk("timeout_o", tmo, e.to);
      end
    end
  end

  initial begin
    bit quiet;
    logic [2:0] rq[2];
    model_clear();
    p_err = 0; p_to = 0; p_id = '0;
    quiet = 0;
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // All harts, accept then delayed response.
    step(1, 1, 3'b111, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(2);
    // Hart 2 idle: missing participation on response.
    step(1, 1, 3'b011, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 32'h12345678, 0, 0, 0, 0);
    idle(2);
    // Spurious response.
    step(1, 1, 0, 0, 1, 32'h0000A5A5, 0, 0, 0, 0);
    idle(2);
    // Overflow on data channel, then drain.
    repeat (3) step(1, 1, 0, 0, 0, 0, 3'b111, 1, 0, 0);
    idle(1);
    repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55AA55AA);
    idle(2);
    // Timeout on data channel, then late spurious response.
    step(1, 1, 0, 0, 0, 0, 3'b111, 1, 0, 0);
    idle(12);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
    idle(2);
    // Bypass mode broadcasts unchanged.
    step(1, 0, 3'b001, 1, 0, 0, 3'b100, 1, 0, 0);
    step(1, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 1, 32'h13579BDF);
    idle(2);
    // Reset mid-transaction; later response is spurious.
    step(1, 1, 3'b111, 1, 0, 0, 3'b111, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 1, 32'h11111111, 0, 0, 1, 32'h22222222);
    idle(2);
    // Randomized traffic with quiet stretches to provoke timeouts.
    for (int n = 0; n < 3000; n++) begin
      if (n % 60 == 0) quiet = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 2; c++)
        rq[c] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 9) != 0),
           rq[0], 1'($urandom_range(0, 1)), !quiet && ($urandom_range(0, 3) == 0), $urandom,
           rq[1], 1'($urandom_range(0, 1)), !quiet && ($urandom_range(0, 3) == 0), $urandom);
    end
    idle(1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
